// File: rtl/event_codes_pkg.sv
// Shared constants for the 3-bit FSM event bus: event codes, FSM status words,
// encoder state encoding and the request-bit-to-code rule.
package event_codes_pkg;

    localparam logic [2:0] EvtNone       = 3'b000;
    localparam logic [2:0] EvtGetTired   = 3'b001;
    localparam logic [2:0] EvtCode2      = 3'b010;
    localparam logic [2:0] EvtCode3      = 3'b011;
    localparam logic [2:0] EvtCode4      = 3'b100;
    localparam logic [2:0] EvtCode5      = 3'b101;
    localparam logic [2:0] EvtAlarmClock = 3'b110;
    localparam logic [2:0] EvtColdWater  = 3'b111;

    localparam logic [5:0] StatusNothing = 6'b100000;
    localparam logic [5:0] StatusSnore   = 6'b100001;
    localparam logic [5:0] StatusUpset   = 6'b100010;
    localparam logic [5:0] StatusLearn   = 6'b100011;

    // Request bit that carries ALARMCLOCK
    localparam int unsigned AlarmBit = 5;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StGap
    } enc_state_e;

    // Request bit i carries event code i+1
    function automatic logic [2:0] code_of_index(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

    // Codes 100..111 are usable while snoring, 001..100 otherwise
    function automatic logic [6:0] eligible_mask(input logic [5:0] status);
        return (status == StatusSnore) ? 7'b1111000 : 7'b0001111;
    endfunction

endpackage

// File: rtl/event_request_encoder_if.sv
// Request/feedback/event bus between stimulus logic, the encoder and the FSM.
// master = encoder side, slave = stimulus/FSM side.
interface event_request_encoder_if #(
    parameter int unsigned ALARM_W = 8
);
    logic [6:0]         evt_req;
    logic               alarm_load;
    logic [ALARM_W-1:0] alarm_value;
    logic [5:0]         status_in;
    logic [2:0]         event_code;
    logic               event_valid;
    logic [6:0]         pending;
    logic               alarm_armed;

    modport master (
        input  evt_req, alarm_load, alarm_value, status_in,
        output event_code, event_valid, pending, alarm_armed
    );

    modport slave (
        output evt_req, alarm_load, alarm_value, status_in,
        input  event_code, event_valid, pending, alarm_armed
    );
endinterface

// File: rtl/alarm_countdown.sv
// Alarm-clock countdown: load/disarm, per-cycle decrement while armed and a
// single-cycle expire pulse on the 1->0 step.
module alarm_countdown #(
    parameter int unsigned ALARM_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ALARM_W-1:0] value,
    output logic               armed,
    output logic               expire
);
    logic [ALARM_W-1:0] count_q, count_d;
    logic               armed_q, armed_d;

    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        expire  = 1'b0;
        if (load) begin
            // A zero value disarms without generating an event
            count_d = value;
            armed_d = (value != '0);
        end else if (armed_q) begin
            count_d = count_q - ALARM_W'(1);
            if (count_q == ALARM_W'(1)) begin
                armed_d = 1'b0;
                expire  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign armed = armed_q;
endmodule

// File: rtl/event_request_encoder.sv
// Event request encoder: latches requests, arbitrates by priority and emits one
// code at a time with idle spacing. Status filter enabled by EVENT_ENC_STATUS_FILTER_EN.
module event_request_encoder
    import event_codes_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned ALARM_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    event_request_encoder_if.master bus
);
    enc_state_e state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [6:0] pending_q, pending_d;
    logic [6:0] mask, eligible, clear, alarm_set;
    logic [2:0] sel;
    logic       expire;

    alarm_countdown #(
        .ALARM_W (ALARM_W)
    ) u_alarm (
        .clk    (clk),
        .reset  (reset),
        .load   (bus.alarm_load),
        .value  (bus.alarm_value),
        .armed  (bus.alarm_armed),
        .expire (expire)
    );

`ifdef EVENT_ENC_STATUS_FILTER_EN
    assign mask = eligible_mask(bus.status_in);
`else
    assign mask = '1;
`endif

    assign eligible  = pending_q & mask;
    assign alarm_set = {1'b0, expire, 5'b0};

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        code_d  = EvtNone;
        valid_d = 1'b0;
        clear   = '0;
        sel     = '0;
        case (state_q)
            StIdle: begin
                // Ineligible requests are dropped at every decision
                clear = ~mask;
                if (eligible != '0) begin
                    for (int i = 0; i < 7; i++) begin
                        if (eligible[i]) sel = 3'(i);
                    end
                    clear[sel] = 1'b1;
                    code_d     = code_of_index(sel);
                    valid_d    = 1'b1;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) state_d = StIdle;
                else                             gap_d   = gap_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase
        // New requests win over a same-edge clear
        pending_d = (pending_q & ~clear) | bus.evt_req | alarm_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            code_q    <= EvtNone;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign bus.event_code  = code_q;
    assign bus.event_valid = valid_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_event_request_encoder.sv
// Scoreboard bench for event_request_encoder; expectations follow the status
// filter setting selected by EVENT_ENC_STATUS_FILTER_EN.
module tb_event_request_encoder;
    import event_codes_pkg::*;

    typedef struct {
        logic [2:0]  code;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    exp_t        sb[$];

    event_request_encoder_if #(.ALARM_W(8)) bus ();

    event_request_encoder #(
        .GAP_CYCLES (2),
        .ALARM_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [2:0] code, input int unsigned cyc);
        exp_t e;
        e.code = code;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    // Every emitted code must match the head of the scoreboard, on its cycle
    always @(negedge clk) begin
        if (bus.event_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", 32'(bus.event_code), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("evt_code", 32'(bus.event_code), 32'(e.code));
                check("evt_cycle", edge_cnt, e.cyc);
            end
        end
    end

    initial begin
        int unsigned e;
        int unsigned n;

        // Reset with everything asserted
        reset           = 1'b0;
        bus.evt_req     = 7'h7F;
        bus.alarm_load  = 1'b1;
        bus.alarm_value = 8'd5;
        bus.status_in   = StatusNothing;
        ticks(2);
        check("rst_code", 32'(bus.event_code), 0);
        check("rst_valid", 32'(bus.event_valid), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_armed", 32'(bus.alarm_armed), 0);
        bus.evt_req    = '0;
        bus.alarm_load = 1'b0;
        reset          = 1'b1;
        ticks(8);
        check("post_rst_pending", 32'(bus.pending), 0);

        // Single event
        bus.evt_req = 7'b0000010;
        tick();
        e = edge_cnt;
        bus.evt_req = '0;
        push(EvtCode2, e + 1);
        tick();
        tick();
        check("single_gap1", 32'(bus.event_code), 0);
        tick();
        check("single_gap2", 32'(bus.event_code), 0);
        ticks(4);
        check("single_pending", 32'(bus.pending), 0);

        // Simultaneous requests while snoring
        bus.status_in = StatusSnore;
        bus.evt_req   = 7'b1000001;
        tick();
        e = edge_cnt;
        bus.evt_req = '0;
        push(EvtColdWater, e + 1);
`ifdef EVENT_ENC_STATUS_FILTER_EN
        tick();
        check("simul_pending", 32'(bus.pending), 0);
`else
        push(EvtGetTired, e + 5);
        tick();
        check("simul_pending", 32'(bus.pending), 32'h01);
`endif
        ticks(10);
        check("simul_drain", 32'(bus.pending), 0);

        // Alarm countdown
        bus.alarm_load  = 1'b1;
        bus.alarm_value = 8'd5;
        tick();
        n = edge_cnt;
        bus.alarm_load = 1'b0;
        push(EvtAlarmClock, n + 6);
        for (int i = 0; i < 5; i++) begin
            check("alarm_armed", 32'(bus.alarm_armed), 1);
            tick();
        end
        tick();
        check("alarm_done", 32'(bus.alarm_armed), 0);
        ticks(6);

        // Disarm before expiry
        bus.alarm_load  = 1'b1;
        bus.alarm_value = 8'd5;
        tick();
        bus.alarm_load = 1'b0;
        tick();
        check("disarm_armed_mid", 32'(bus.alarm_armed), 1);
        bus.alarm_load  = 1'b1;
        bus.alarm_value = 8'd0;
        tick();
        bus.alarm_load = 1'b0;
        check("disarm_armed", 32'(bus.alarm_armed), 0);
        ticks(10);
        check("disarm_pending", 32'(bus.pending), 0);

        // Reset during GAP with 101 pending
        bus.status_in = StatusNothing;
        bus.evt_req   = 7'b0000010;
        tick();
        e = edge_cnt;
        bus.evt_req = '0;
        push(EvtCode2, e + 1);
        tick();
        bus.evt_req = 7'b0010000;
        tick();
        bus.evt_req = '0;
        check("gap_pending", 32'(bus.pending), 32'h10);
        reset = 1'b0;
        tick();
        check("gaprst_pending", 32'(bus.pending), 0);
        check("gaprst_code", 32'(bus.event_code), 0);
        check("gaprst_valid", 32'(bus.event_valid), 0);
        reset = 1'b1;
        ticks(10);
        check("gaprst_after", 32'(bus.pending), 0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/event_request_encoder.md
# event_request_encoder

Transmit side of the 3-bit FSM event bus. Latches asynchronous-in-time event requests from the surrounding stimulus logic, arbitrates them by priority, and drives one event code at a time onto the FSM `input_signal` port, with enforced idle spacing between codes. It also owns an alarm-clock countdown that generates ALARMCLOCK events autonomously. The FSM's 6-bit status output is fed back so that events the current state cannot use are discarded.

## Interface
- `GAP_CYCLES`, 2: number of idle (code 000) cycles forced after each emitted code, 1..15.
- `ALARM_W`, 8: width of the alarm countdown.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset. Only one clock exists.
- `evt_req` in 7: request strobes. Bit i requests event code i+1, so bit0 is GETTIRED (001) and bit6 is COLDWATER (111).
- `alarm_load` in 1: loads or disarms the alarm.
- `alarm_value` in ALARM_W: countdown value. A value of 0 means disarm.
- `status_in` in 6: FSM status feedback. Values: NOTHING=100000, SNORE=100001, UPSET=100010, LEARN=100011.
- `event_code` out 3: drives the FSM input. 000 means no event.
- `event_valid` out 1: high only in the cycle a nonzero code is driven.
- `pending` out 7: latched requests not yet emitted or dropped.
- `alarm_armed` out 1: countdown is active.

## Operation
- Reset values: `event_code`=000, `event_valid`=0, `pending`=0, `alarm_armed`=0, countdown=0, state=IDLE.
- Pending latch: `pending[i]` is set on any edge where `evt_req[i]`=1. If set and clear of the same bit occur on the same edge, set wins.
- State machine states are IDLE, EMIT and GAP.
- IDLE:
  - Compute eligible = `pending` & mask.
  - If eligible is nonzero, select the highest eligible index (COLDWATER highest priority, GETTIRED lowest), register its code, clear that pending bit, and go to EMIT.
  - Ineligible pending bits are cleared on the same edge, whether or not an event is selected.
  - If eligible is zero, stay in IDLE.
- EMIT: `event_code` holds the selected code and `event_valid`=1 for exactly one cycle. Then go to GAP.
- GAP: `event_code`=000 for GAP_CYCLES cycles, counted by a 4-bit gap counter. Then go to IDLE. Requests keep latching during EMIT and GAP.
- Eligibility mask:
  - `status_in`=SNORE: codes 100, 101, 110 and 111 are eligible; 001, 010 and 011 are ineligible.
  - Any other status: codes 001, 010, 011 and 100 are eligible; 101, 110 and 111 are ineligible.
- Alarm countdown:
  - `alarm_load`=1 with a nonzero value: countdown ← `alarm_value` and `alarm_armed`=1. This restarts the countdown if it is already armed.
  - `alarm_load`=1 with value 0: countdown ← 0 and `alarm_armed`=0. No event is generated.
  - While armed, the countdown decrements by 1 every edge. On the 1→0 edge, `pending[5]` (ALARMCLOCK, 110) is set and `alarm_armed` is cleared.
  - `alarm_load` takes precedence over decrement.
- A low on `reset` in any state, including EMIT and GAP, restores all reset values on that edge. Pending requests are discarded.

## Timing
- Request sampled at edge n gives `pending` set after edge n. Selection happens in the following cycle, and `event_code`/`event_valid` are valid after edge n+1. Minimum latency is 2 edges from the request cycle.
- Throughput: at most one code per 1+GAP_CYCLES+1 cycles (EMIT, GAP, IDLE decision).
- Alarm: load at edge n, code 110 visible after edge n+`alarm_value`+1, provided the status is SNORE and no higher-priority eligible event is pending.
- `status_in` is sampled only in IDLE. It is registered by the FSM, so GAP_CYCLES≥1 guarantees the feedback reflects the previous event.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `EVENT_ENC_STATUS_FILTER_EN`:
  - Defined: the eligibility mask applies as described above.
  - Undefined: the mask is all ones and nothing is ever dropped. Pure priority order is used and `status_in` is unused.

## Structure
- Shared package `event_codes_pkg` holds:
  - the 3-bit event code constants (001..111 plus NONE=000),
  - the 6-bit status constants,
  - the IDLE/EMIT/GAP state encoding,
  - the bit-index-to-code rule.
- One sub-module, `alarm_countdown` (ALARM_W), handles load, disarm, decrement, `armed` and a one-cycle `expire` pulse. The top level ORs `expire` into `pending[5]`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `evt_req`=7'h7F and `alarm_load`=1. Required: all outputs 0 and `pending`=0. No code appears after release until a new request.
- **Single event:** `status_in`=100000, `evt_req`=7'b0000010 at edge n. Required: `event_code`=010 with `event_valid`=1 after edge n+1 only, then 000 for 2 cycles.
- **Simultaneous requests, filter on:** `status_in`=SNORE, `evt_req`=7'b1000001. Required: 111 emitted and `pending`=0 after the decision. With the macro undefined, 111 is emitted and then 001 appears 4 cycles later.
- **Alarm:** `alarm_load`=1 with `alarm_value`=5 at edge n, status SNORE. Required: `alarm_armed` is 1 from n to n+5 and 0 from n+6; `event_code`=110 after edge n+6.
- **Disarm:** load 5, then 2 cycles later load 0. Required: `alarm_armed`=0 and code 110 is never emitted.
- **Reset mid-GAP:** with `pending`=7'b0010000, assert `reset`=0 during GAP. Required: `pending`=0 and state IDLE. No 101 is emitted after release.
